mem: RTL and testbench



---
 rtl/mem.sv | 168 ++++++++++++++++
 tb/tb_mem.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/mem.sv
// ----------------------------------------------------------------------------
// mem: ternary (TCAM) routing memory for a spiking-neuron fabric.
//
// Holds Words entries of Bits bits. Each entry has a data field, a don't-care
// field and a valid bit. A lookup matches the packet source ID against the
// upper ID_Width bits of every valid entry. An explicit compare (CMP_In) uses a
// caller-supplied key, a per-bit mask and per-bank enables. The lowest matching
// index wins. Its destination ID and weight pointer appear on the outputs one
// cycle after the request.
//
// Entry layout: {SrcID[Bits-1:Bits-ID_Width], DstID[ID_Width-1:0]}.
//
// Ports:
//   clk          clock, all state changes on the rising edge
//   rst_n        asynchronous active-low reset
//   CS           chip select; nothing happens while low
//   FLUSH        invalidate every entry (highest priority)
//   WR           write the field selected by DCS at Addr_In
//   CMP_In       explicit masked compare
//   DCS          write field select: 1 = data, 0 = don't-care
//   VBE / VBI    valid-bit write enable / value
//   Data_In      write data or compare key
//   Mask_In      per-bit write enable (write) or compare enable (compare)
//   CBE          per-bank compare enable for CMP_In
//   Addr_In      write address
//   PacketID_In  lookup key
//   DstID_Out    destination ID of the winning entry (registered)
//   Weight_Out   index of the winning entry (registered)
//
// Configuration macro:
//   MEM_MISS_HOLD_EN  defined: a miss holds the outputs.
//                     undefined (default): a miss clears the outputs to 0.
// ----------------------------------------------------------------------------
module mem #(
    parameter int ID_Width     = 4,
    parameter int Weight_Width = 4,
    parameter int AddressSize  = 4,
    parameter int Bits         = 8,
    parameter int Words        = 16,
    parameter int BankSize     = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    CS,
    input  logic                    FLUSH,
    input  logic                    WR,
    input  logic                    CMP_In,
    input  logic                    DCS,
    input  logic                    VBE,
    input  logic                    VBI,
    input  logic [Bits-1:0]         Data_In,
    input  logic [Bits-1:0]         Mask_In,
    input  logic [BankSize-1:0]     CBE,
    input  logic [AddressSize-1:0]  Addr_In,
    input  logic [ID_Width-1:0]     PacketID_In,
    output logic [ID_Width-1:0]     DstID_Out,
    output logic [Weight_Width-1:0] Weight_Out
);

    localparam int BankWords = Words / BankSize;

    // Entry storage
    logic [Bits-1:0]  data_q [Words];
    logic [Bits-1:0]  dc_q   [Words];
    logic [Words-1:0] valid_q;

    // Registered result
    logic [ID_Width-1:0]     dst_q, dst_d;
    logic [Weight_Width-1:0] wgt_q, wgt_d;

    // Search key, compare mask and bank enables for this cycle
    logic [Bits-1:0]     key;
    logic [Bits-1:0]     cmp_mask;
    logic [BankSize-1:0] bank_en;

    logic [Words-1:0]       match;
    logic                   hit;
    logic [AddressSize-1:0] hit_idx;

    // A lookup places the packet ID in the SrcID field and compares only
    // that field; an explicit compare takes key and mask from the caller.
    always_comb begin
        key      = Bits'(PacketID_In) << (Bits - ID_Width);
        cmp_mask = Bits'({ID_Width{1'b1}}) << (Bits - ID_Width);
        bank_en  = '1;
        if (CMP_In) begin
            key      = Data_In;
            cmp_mask = Mask_In;
            bank_en  = CBE;
        end
    end

    always_comb begin
        match = '0;
        for (int i = 0; i < Words; i++) begin
            match[i] = valid_q[i]
                    && bank_en[i / BankWords]
                    && (((key ^ data_q[i]) & cmp_mask & ~dc_q[i]) == '0);
        end
    end

    // Priority encoder: scan from the top so the lowest matching index is the
    // last one assigned and therefore wins.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = Words - 1; i >= 0; i--) begin
            if (match[i]) begin
                hit     = 1'b1;
                hit_idx = AddressSize'(i);
            end
        end
    end

    // Next result for a lookup or compare; a miss either holds or clears.
    always_comb begin
        dst_d = dst_q;
        wgt_d = wgt_q;
        if (hit) begin
            dst_d = data_q[hit_idx][ID_Width-1:0];
            wgt_d = Weight_Width'(hit_idx);
        end else begin
`ifdef MEM_MISS_HOLD_EN
            dst_d = dst_q;
            wgt_d = wgt_q;
`else
            dst_d = '0;
            wgt_d = '0;
`endif
        end
    end

    // NOTE: the entry arrays are reset explicitly because reset must leave
    // every field at 0; a plain RAM macro could not be used for this storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < Words; i++) begin
                data_q[i] <= '0;
                dc_q[i]   <= '0;
            end
            valid_q <= '0;
            dst_q   <= '0;
            wgt_q   <= '0;
        end else if (CS) begin
            if (FLUSH) begin
                // Only the valid bits are cleared; field contents survive.
                valid_q <= '0;
            end else if (WR) begin
                if (DCS) begin
                    data_q[Addr_In] <= (data_q[Addr_In] & ~Mask_In) | (Data_In & Mask_In);
                end else begin
                    dc_q[Addr_In]   <= (dc_q[Addr_In] & ~Mask_In) | (Data_In & Mask_In);
                end
                if (VBE) begin
                    valid_q[Addr_In] <= VBI;
                end
            end else begin
                // Explicit compare or lookup
                dst_q <= dst_d;
                wgt_q <= wgt_d;
            end
        end
    end

    assign DstID_Out  = dst_q;
    assign Weight_Out = wgt_q;

endmodule

// File: tb/tb_mem.sv
// ----------------------------------------------------------------------------
// tb_mem: directed bench for the mem TCAM. Every lookup/compare pushes its
// expected result into a scoreboard queue; the result is popped and compared
// one cycle later, on the falling edge, away from the sampling edge.
// ----------------------------------------------------------------------------
module tb_mem;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       CS, FLUSH, WR, CMP_In, DCS, VBE, VBI;
    logic [7:0] Data_In, Mask_In;
    logic [0:0] CBE;
    logic [3:0] Addr_In, PacketID_In;
    logic [3:0] DstID_Out, Weight_Out;

    mem dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .CS          (CS),
        .FLUSH       (FLUSH),
        .WR          (WR),
        .CMP_In      (CMP_In),
        .DCS         (DCS),
        .VBE         (VBE),
        .VBI         (VBI),
        .Data_In     (Data_In),
        .Mask_In     (Mask_In),
        .CBE         (CBE),
        .Addr_In     (Addr_In),
        .PacketID_In (PacketID_In),
        .DstID_Out   (DstID_Out),
        .Weight_Out  (Weight_Out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] dst;
        logic [3:0] wgt;
    } result_t;

    result_t sb[$];
    result_t last;      // value the outputs currently hold, per the model
    int      n_assert = 0;
    int      n_fail   = 0;

    // Record the expected output of the next lookup/compare.
    task automatic expect_result(input logic is_hit, input logic [3:0] dst, input logic [3:0] wgt);
        result_t r;
        if (is_hit) begin
            r.dst = dst;
            r.wgt = wgt;
        end else begin
`ifdef MEM_MISS_HOLD_EN
            r = last;
`else
            r = '0;
`endif
        end
        last = r;
        sb.push_back(r);
    endtask

    // Expect the outputs to stay where they are.
    task automatic expect_hold();
        sb.push_back(last);
    endtask

    task automatic check(input string tag);
        result_t e;
        if (sb.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL %s: scoreboard empty, observed %0h/%0h", tag, DstID_Out, Weight_Out);
        end else begin
            e = sb.pop_front();
            n_assert++;
            assert (DstID_Out === e.dst) else begin
                n_fail++;
                $error("FAIL %s dst: observed %0h expected %0h", tag, DstID_Out, e.dst);
            end
            n_assert++;
            assert (Weight_Out === e.wgt) else begin
                n_fail++;
                $error("FAIL %s wgt: observed %0h expected %0h", tag, Weight_Out, e.wgt);
            end
        end
    endtask

    // Drive one request for one clock; inputs change on the falling edge.
    task automatic drive(input logic cs, input logic flush, input logic wr, input logic cmp,
                         input logic dcs, input logic vbe, input logic vbi,
                         input logic [7:0] data, input logic [7:0] mask, input logic cbe,
                         input logic [3:0] addr, input logic [3:0] pid);
        CS = cs; FLUSH = flush; WR = wr; CMP_In = cmp; DCS = dcs; VBE = vbe; VBI = vbi;
        Data_In = data; Mask_In = mask; CBE = cbe; Addr_In = addr; PacketID_In = pid;
        @(posedge clk);
        @(negedge clk);
        CS = 1'b0; FLUSH = 1'b0; WR = 1'b0; CMP_In = 1'b0;
    endtask

    task automatic write(input logic [3:0] addr, input logic dcs, input logic [7:0] data,
                         input logic [7:0] mask, input logic vbe, input logic vbi);
        drive(1'b1, 1'b0, 1'b1, 1'b0, dcs, vbe, vbi, data, mask, 1'b0, addr, 4'h0);
    endtask

    task automatic lookup(input logic [3:0] pid, input logic is_hit, input logic [3:0] dst,
                          input logic [3:0] wgt, input string tag);
        expect_result(is_hit, dst, wgt);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, pid);
        check(tag);
    endtask

    task automatic compare(input logic [7:0] key, input logic [7:0] mask, input logic cbe,
                           input logic is_hit, input logic [3:0] dst, input logic [3:0] wgt,
                           input string tag);
        expect_result(is_hit, dst, wgt);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, key, mask, cbe, 4'h0, 4'h0);
        check(tag);
    endtask

    initial begin
        logic [3:0] nib;
        last = '0;
        rst_n = 1'b0;
        CS = 1'b0; FLUSH = 1'b0; WR = 1'b0; CMP_In = 1'b0; DCS = 1'b0; VBE = 1'b0; VBI = 1'b0;
        Data_In = '0; Mask_In = '0; CBE = '0; Addr_In = '0; PacketID_In = '0;
        repeat (2) @(negedge clk);
        expect_hold();
        check("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Empty memory: lookup misses
        lookup(4'd3, 1'b0, 4'd0, 4'd0, "empty_miss");

        // Fill entries with {i,i} and clear every don't-care field
        for (int i = 0; i < 16; i++) begin
            nib = 4'(i);
            write(nib, 1'b1, {nib, nib}, 8'hFF, 1'b1, 1'b1);
        end
        for (int i = 0; i < 16; i++) begin
            write(4'(i), 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
        end
        lookup(4'd5, 1'b1, 4'd5, 4'd5, "lookup5");
        lookup(4'd0, 1'b1, 4'd0, 4'd0, "lookup0_index0");

        // Entry 2 ignores its SrcID, so it beats entry 9
        write(4'd2, 1'b0, 8'hF0, 8'hFF, 1'b0, 1'b0);
        lookup(4'd9, 1'b1, 4'd2, 4'd2, "dontcare_priority");

        // Partial data write: 0x11 with low nibble from 0xAA -> 0x1A
        write(4'd1, 1'b1, 8'hAA, 8'h0F, 1'b0, 1'b0);
        lookup(4'd1, 1'b1, 4'hA, 4'd1, "partial_write");

        // Explicit compare, bank enabled then disabled
        compare(8'h77, 8'hFF, 1'b1, 1'b1, 4'd7, 4'd7, "cmp_hit");
        compare(8'h77, 8'hFF, 1'b0, 1'b0, 4'd0, 4'd0, "cmp_bank_off");
        // Low-nibble-only compare: only entry 15 (0xFF) has low nibble F
        compare(8'h0F, 8'h0F, 1'b1, 1'b1, 4'd15, 4'd15, "cmp_mask_top");

        // CS low: request ignored, outputs hold
        expect_hold();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 4'd4);
        check("cs_low_hold");

        // Write wins over a lookup in the same cycle: outputs hold
        expect_hold();
        drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'hFF, 1'b0, 4'd3, 4'd4);
        check("wr_over_lookup");

        // Flush invalidates everything
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 4'h0, 4'h0);
        lookup(4'd4, 1'b0, 4'd0, 4'd0, "flush_miss");
        write(4'd4, 1'b1, 8'h44, 8'hFF, 1'b1, 1'b1);
        lookup(4'd4, 1'b1, 4'd4, 4'd4, "rewrite4");
        lookup(4'd5, 1'b0, 4'd0, 4'd0, "flushed5_miss");

        // Re-validate entry 6 without touching data: contents survived flush
        write(4'd6, 1'b1, 8'h00, 8'h00, 1'b1, 1'b1);
        lookup(4'd6, 1'b1, 4'd6, 4'd6, "flush_keeps_data");

        // VBE=0 write leaves the valid bit alone
        write(4'd4, 1'b0, 8'h00, 8'hFF, 1'b0, 1'b0);
        lookup(4'd4, 1'b1, 4'd4, 4'd4, "vbe0_keeps_valid");

        // Back-to-back lookups
        lookup(4'd6, 1'b1, 4'd6, 4'd6, "b2b_a");
        lookup(4'd4, 1'b1, 4'd4, 4'd4, "b2b_b");
        lookup(4'd6, 1'b1, 4'd6, 4'd6, "b2b_c");

        // Asynchronous reset in the middle of a lookup
        CS = 1'b1; PacketID_In = 4'd4;
        #2 rst_n = 1'b0;
        #1;
        last = '0;
        expect_hold();
        check("async_reset");
        CS = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        lookup(4'd6, 1'b0, 4'd0, 4'd0, "post_reset_miss");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // Safety net so the run always ends
    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

endmodule
